fifo_flex: RTL
==============

Name: fifo_flex

Overview:
Parametrised synchronous FIFO that succeeds the fixed 8-bit, 8-entry FIFO.
- Width, depth and almost-full/almost-empty thresholds are configurable.
- Read mode is selectable: registered-read or first-word-fall-through (FWFT).
- Adds an occupancy count and sticky overflow/underflow error flags.
- Sits between producer and consumer logic in the same clock domain, as the general-purpose buffer for lab datapaths.

Parameters:
DATA_WIDTH, 8, width of i_data/o_data.
DEPTH, 8, number of entries; must be a power of 2 and >= 2.
AF_THRESH, 6, almost_full asserts when count >= AF_THRESH.
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH.
FWFT, 0, 0 = registered read (data one cycle after rden); 1 = head entry presented without a read.

Ports:
clk  input  1  clock; all logic on rising edge.
rst_n  input  1  asynchronous active-low reset.
wren  input  1  write request.
i_data  input  DATA_WIDTH  write data.
rden  input  1  read/pop request.
o_data  output  DATA_WIDTH  read data.
o_valid  output  1  o_data holds valid popped/head data.
full  output  1  count == DEPTH.
empty  output  1  count == 0.
almost_full  output  1  count >= AF_THRESH.
almost_empty  output  1  count <= AE_THRESH.
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
overflow  output  1  sticky: a write was dropped.
underflow  output  1  sticky: a read was rejected.
clr_err  input  1  synchronous clear of overflow/underflow.

Behaviour:
- Reset (async, rst_n=0):
  - Pointers and count go to 0; empty=1, full=0.
  - almost_empty=1; almost_full=0 (AF_THRESH >= 1).
  - o_data=0, o_valid=0, overflow=0, underflow=0.
  - Reset mid-operation discards all contents immediately; memory contents need not be cleared.
- Pointers: rd_ptr/wr_ptr are $clog2(DEPTH)+1 bits, wrap naturally modulo 2*DEPTH. count = wr_ptr - rd_ptr. All flags derive from registered pointers, so there is no combinational path from wren/rden to the flags.
- Write accept: wr_ok = wren && (!full || rd_ok).
  - On accept: mem[wr_ptr] <= i_data, wr_ptr increments.
  - wren && !wr_ok sets overflow; the data is dropped and state is otherwise unchanged.
- Read accept: rd_ok = rden && !empty.
  - On accept, rd_ptr increments.
  - rden && empty sets underflow; there is no pop.
  - A write in the same cycle as a read on empty is accepted, but the read is still rejected: no bypass.
- Simultaneous read and write when full: both are accepted, count stays at DEPTH, full stays 1, no overflow.
- Simultaneous read and write at 0 < count < DEPTH: count unchanged.
- FWFT=0 (registered read):
  - On rd_ok at edge N: o_data <= mem[rd_ptr] and o_valid=1 during cycle N+1.
  - o_valid is 0 on any cycle not following an rd_ok.
  - o_data holds its last value when no read occurs.
- FWFT=1:
  - o_data = mem[rd_ptr] combinationally; o_valid = !empty.
  - A written word appears on o_data the cycle after its write edge.
  - rden pops the head; the next entry is presented in the following cycle.
- Sticky flags:
  - Set on error, cleared by clr_err=1 at the next edge.
  - If clr_err and a new error occur in the same cycle, set wins (flag=1).
- Thresholds: almost_full and almost_empty are compared against count each cycle; both may be 1 at once when DEPTH is small.

Test Plan:
- Reset then idle, FWFT=0, DEPTH=8 -> empty=1, count=0, almost_empty=1, o_valid=0, o_data=0.
- Write 0x1E, then pulse rden one cycle later -> next cycle o_valid=1, o_data=0x1E; then empty=1, count=0.
- Write 0x10..0x17 (8 writes) -> full=1, count=8, almost_full from count=6. A 9th write of 0xAA -> overflow=1, count=8. Read all 8 -> o_data sequence 0x10..0x17; 0xAA never appears.
- With full=1, assert wren=1 (0x55) and rden=1 for one cycle -> o_data=0x10, count stays 8, overflow stays 0. Drain -> last word read is 0x55 (verifies pointer wrap).
- rden on empty -> underflow=1, o_valid=0. clr_err next cycle -> underflow=0. clr_err together with another empty rden -> underflow remains 1.
- FWFT=1 build: write 0x01 then 0xFF -> o_data=0x01 and o_valid=1 the cycle after the first write edge. rden -> o_data=0xFF next cycle. rden again -> empty=1, o_valid=0. Assert rst_n=0 with 3 entries queued -> count=0, empty=1 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_flex_if.sv
// Producer/consumer side of fifo_flex: write/read requests, data and status.
// The master side drives requests; the slave side (the FIFO) drives status.
interface fifo_flex_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8
);
    logic                       wren;
    logic [DATA_WIDTH-1:0]      i_data;
    logic                       rden;
    logic                       clr_err;
    logic [DATA_WIDTH-1:0]      o_data;
    logic                       o_valid;
    logic                       full;
    logic                       empty;
    logic                       almost_full;
    logic                       almost_empty;
    logic [$clog2(DEPTH):0]     count;
    logic                       overflow;
    logic                       underflow;

    modport master (
        output wren, i_data, rden, clr_err,
        input  o_data, o_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wren, i_data, rden, clr_err,
        output o_data, o_valid, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_flex.sv
// Parametrised synchronous FIFO with registered-read or FWFT output,
// occupancy count, almost thresholds and sticky overflow/underflow flags.
module fifo_flex #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    fifo_flex_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]           r_wr_ptr;
    logic [AW:0]           r_rd_ptr;
    logic                  r_overflow;
    logic                  r_underflow;

    logic [AW:0]           w_count;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_rd_ok;
    logic                  w_wr_ok;

    // Status depends only on registered pointers, never on this cycle's requests.
    assign w_count = r_wr_ptr - r_rd_ptr;
    assign w_full  = (w_count == C_DEPTH);
    assign w_empty = (w_count == '0);
    assign w_rd_ok = bus.rden && !w_empty;
    assign w_wr_ok = bus.wren && (!w_full || w_rd_ok);

    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.i_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    // A new error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= (r_overflow  && !bus.clr_err) || (bus.wren && !w_wr_ok);
            r_underflow <= (r_underflow && !bus.clr_err) || (bus.rden && w_empty);
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Gate with empty so the output reads zero while nothing is queued.
            assign bus.o_data  = w_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];
            assign bus.o_valid = !w_empty;
        end else begin : g_regread
            logic [DATA_WIDTH-1:0] r_o_data;
            logic                  r_o_valid;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_o_data  <= '0;
                    r_o_valid <= 1'b0;
                end else begin
                    r_o_valid <= w_rd_ok;
                    if (w_rd_ok) begin
                        r_o_data <= r_mem[r_rd_ptr[AW-1:0]];
                    end
                end
            end

            assign bus.o_data  = r_o_data;
            assign bus.o_valid = r_o_valid;
        end
    endgenerate

    assign bus.full         = w_full;
    assign bus.empty        = w_empty;
    assign bus.count        = w_count;
    assign bus.almost_full  = (int'(w_count) >= AF_THRESH);
    assign bus.almost_empty = (int'(w_count) <= AE_THRESH);
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule
